// File: rtl/conf_merge_pkg.sv
// ---------------------------------------------------------------------------
// conf_merge_pkg
// Shared types and constants for the configuration merge arbiter.
//   state_t      : arbiter FSM state encoding (2 bits)
//   ERR_*        : bit positions inside the sticky error vector
// ---------------------------------------------------------------------------
package conf_merge_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRIVE     = 2'd1,
        WAIT_FREE = 2'd2,
        RELEASE   = 2'd3
    } state_t;

    localparam int ERR_OVERRUN  = 0;
    localparam int ERR_SPURIOUS = 1;
    localparam int ERR_TIMEOUT  = 2;
    localparam int ERR_W        = 3;

endpackage

// File: rtl/rr_pick_n.sv
// ---------------------------------------------------------------------------
// rr_pick_n
// Combinational round-robin picker. Searches req upward starting one past
// ptr, wrapping at N_PORTS-1, and returns the first set bit.
// Ports:
//   req  in  N_PORTS  request vector
//   ptr  in  IDX_W    index of the most recently served port
//   any  out 1        at least one request is set
//   idx  out IDX_W    selected port (0 when any is low)
// ---------------------------------------------------------------------------
module rr_pick_n
    import conf_merge_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_PORTS - 1);

    always_comb begin
        logic [IDX_W-1:0] k;
        any = 1'b0;
        idx = '0;
        k   = ptr;
        // Walk N_PORTS candidates; the wrap compare keeps k in range even
        // when N_PORTS is not a power of two.
        for (int i = 0; i < N_PORTS; i++) begin
            k = (k == LAST) ? '0 : k + IDX_W'(1);
            if (!any && req[k]) begin
                any = 1'b1;
                idx = k;
            end
        end
    end

endmodule

// File: rtl/conf_merge_arbiter.sv
// ---------------------------------------------------------------------------
// conf_merge_arbiter
// Shares one downstream drive/free channel between N_PORTS requesters with
// round-robin fairness and a single outstanding transaction. Detects
// overrun, spurious free and resource timeout (forced release).
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   i_drive        in   per-port one-cycle request pulses
//   o_free         out  one-cycle completion pulse to the served port
//   o_driveNext    out  one-cycle drive pulse to the shared resource
//   i_freeNext     in   one-cycle completion pulse from the resource
//   o_owner        out  index of the served port (valid while o_busy)
//   o_busy         out  high from grant until release completes
//   i_clr_err      in   synchronous clear of the sticky error flags
//   o_err_overrun  out  sticky: request while the same port was pending
//   o_err_spurious out  sticky: i_freeNext outside WAIT_FREE
//   o_err_timeout  out  sticky: forced release occurred
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no transaction; grant the next pending port round-robin
// DRIVE     | o_driveNext high for this cycle; timeout counter cleared
// WAIT_FREE | waiting for i_freeNext, counting toward forced release
// RELEASE   | o_free[owner] high for this cycle; rr pointer moves to owner
// ---------------------------------------------------------------------------
module conf_merge_arbiter
    import conf_merge_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int IDX_W   = $clog2(N_PORTS),
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] i_drive,
    output logic [N_PORTS-1:0] o_free,
    output logic               o_driveNext,
    input  logic               i_freeNext,
    output logic [IDX_W-1:0]   o_owner,
    output logic               o_busy,
    input  logic               i_clr_err,
    output logic               o_err_overrun,
    output logic               o_err_spurious,
    output logic               o_err_timeout
);

    localparam logic [N_PORTS-1:0] ONE_HOT0 = N_PORTS'(1);
    localparam logic [IDX_W-1:0]   PTR_RST  = IDX_W'(N_PORTS - 1);
    localparam bit                 TO_EN    = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]    TO_LAST  = TO_EN ? TO_W'(TIMEOUT - 1) : '0;

    state_t             state;
    logic [N_PORTS-1:0] pend;
    logic [N_PORTS-1:0] pend_next;
    logic [N_PORTS-1:0] grant_mask;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic               grant;
    logic               to_fire;
    logic [TO_W-1:0]    cnt;
    logic [ERR_W-1:0]   err;
    logic [ERR_W-1:0]   err_evt;
    logic [ERR_W-1:0]   err_next;

    rr_pick_n #(
        .N_PORTS (N_PORTS),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req (pend),
        .ptr (rr_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        grant      = (state == IDLE) && pick_any;
        grant_mask = grant ? (ONE_HOT0 << pick_idx) : '0;

        // The grant only sees pend as registered, so a pulse arriving in the
        // grant cycle lands in pend for the next decision. A pulse on a port
        // that is already pending is dropped and flagged.
        pend_next = (pend & ~grant_mask) | (i_drive & ~pend);

        to_fire = TO_EN && (state == WAIT_FREE) && !i_freeNext && (cnt == TO_LAST);

        err_evt               = '0;
        err_evt[ERR_OVERRUN]  = |(i_drive & pend);
        err_evt[ERR_SPURIOUS] = i_freeNext && (state != WAIT_FREE);
        err_evt[ERR_TIMEOUT]  = to_fire;

        // A new error event wins over a clear in the same cycle.
        err_next = (i_clr_err ? '0 : err) | err_evt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= '0;
            rr_ptr      <= PTR_RST;
            cnt         <= '0;
            o_owner     <= '0;
            o_busy      <= 1'b0;
            o_driveNext <= 1'b0;
            o_free      <= '0;
            err         <= '0;
        end else begin
            pend        <= pend_next;
            err         <= err_next;
            o_driveNext <= 1'b0;
            o_free      <= '0;

            case (state)
                IDLE: begin
                    if (grant) begin
                        o_owner     <= pick_idx;
                        o_busy      <= 1'b1;
                        o_driveNext <= 1'b1;
                        state       <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt   <= '0;
                    state <= WAIT_FREE;
                end
                WAIT_FREE: begin
                    if (i_freeNext || to_fire) begin
                        o_free <= ONE_HOT0 << o_owner;
                        state  <= RELEASE;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                RELEASE: begin
                    rr_ptr <= o_owner;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_err_overrun  = err[ERR_OVERRUN];
    assign o_err_spurious = err[ERR_SPURIOUS];
    assign o_err_timeout  = err[ERR_TIMEOUT];

endmodule

// File: tb/tb_conf_merge_arbiter.sv
module tb_conf_merge_arbiter;

    typedef struct {
        int         cyc;
        logic [3:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] i_drive;
    logic [3:0] o_free;
    logic       o_driveNext;
    logic       i_freeNext;
    logic [1:0] o_owner;
    logic       o_busy;
    logic       i_clr_err;
    logic       o_err_overrun;
    logic       o_err_spurious;
    logic       o_err_timeout;

    int   cyc;
    int   n_cmp;
    int   n_fail;
    exp_t dq[$];
    exp_t fq[$];

    conf_merge_arbiter #(
        .N_PORTS (4),
        .IDX_W   (2),
        .TIMEOUT (8),
        .TO_W    (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_drive        (i_drive),
        .o_free         (o_free),
        .o_driveNext    (o_driveNext),
        .i_freeNext     (i_freeNext),
        .o_owner        (o_owner),
        .o_busy         (o_busy),
        .i_clr_err      (i_clr_err),
        .o_err_overrun  (o_err_overrun),
        .o_err_spurious (o_err_spurious),
        .o_err_timeout  (o_err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, required %0h", nm, cyc, act, req);
        end
    endtask

    task automatic push_d(input int cy, input int own);
        exp_t e;
        e.cyc = cy;
        e.val = 4'(own);
        dq.push_back(e);
    endtask

    task automatic push_f(input int cy, input logic [3:0] mask);
        exp_t e;
        e.cyc = cy;
        e.val = mask;
        fq.push_back(e);
    endtask

    initial begin
        rst        = 1'b1;
        i_drive    = '0;
        i_freeNext = 1'b0;
        i_clr_err  = 1'b0;
        cyc        = 0;
        n_cmp      = 0;
        n_fail     = 0;

        // Monitor: pops the scoreboard whenever the DUT emits a pulse.
        fork
            begin
                exp_t m;
                forever begin
                    @(negedge clk);
                    if (o_driveNext && (o_free != 4'b0000)) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL drive_free_overlap @cycle %0d: free=%b with driveNext=1, required no overlap", cyc, o_free);
                    end
                    if (o_driveNext) begin
                        n_cmp++;
                        if (dq.size() == 0) begin
                            n_fail++;
                            $display("FAIL drive_unexpected @cycle %0d: owner %0d, required no drive", cyc, o_owner);
                        end else begin
                            m = dq.pop_front();
                            if (cyc != m.cyc || {2'b00, o_owner} != m.val) begin
                                n_fail++;
                                $display("FAIL drive @cycle %0d owner %0d, required cycle %0d owner %0d", cyc, o_owner, m.cyc, m.val);
                            end
                        end
                    end
                    if (o_free != 4'b0000) begin
                        n_cmp++;
                        if (fq.size() == 0) begin
                            n_fail++;
                            $display("FAIL free_unexpected @cycle %0d: free=%b, required none", cyc, o_free);
                        end else begin
                            m = fq.pop_front();
                            if (cyc != m.cyc || o_free != m.val) begin
                                n_fail++;
                                $display("FAIL free @cycle %0d mask %b, required cycle %0d mask %b", cyc, o_free, m.cyc, m.val);
                            end
                        end
                    end
                end
            end
        join_none

        for (int c = 1; c <= 140; c++) begin
            @(posedge clk);
            #1;
            cyc        = c;
            i_drive    = '0;
            i_freeNext = 1'b0;
            i_clr_err  = 1'b0;

            case (c)
                2:   rst = 1'b0;
                // fairness: all four pending, port 0 re-requests after its grant
                10:  begin i_drive = 4'b1111; push_d(12, 0); push_d(16, 1); push_d(20, 2); push_d(24, 3); end
                13:  begin i_drive = 4'b0001; push_d(28, 0); i_freeNext = 1'b1; push_f(14, 4'b0001); end
                17:  begin i_freeNext = 1'b1; push_f(18, 4'b0010); end
                21:  begin i_freeNext = 1'b1; push_f(22, 4'b0100); end
                25:  begin i_freeNext = 1'b1; push_f(26, 4'b1000); end
                29:  begin i_freeNext = 1'b1; push_f(30, 4'b0001); end
                // single request; free lands in the last WAIT_FREE cycle
                40:  begin i_drive = 4'b0100; push_d(42, 2); end
                50:  begin i_freeNext = 1'b1; push_f(51, 4'b0100); end
                // overrun: back-to-back pulses on port 1
                60:  begin i_drive = 4'b0010; push_d(62, 1); end
                61:  i_drive = 4'b0010;
                63:  begin i_freeNext = 1'b1; push_f(64, 4'b0010); end
                70:  i_clr_err = 1'b1;
                // timeout on port 3, port 0 waiting behind it
                80:  begin i_drive = 4'b1000; push_d(82, 3); push_f(91, 4'b1000); end
                84:  begin i_drive = 4'b0001; push_d(93, 0); end
                94:  begin i_freeNext = 1'b1; push_f(95, 4'b0001); end
                // spurious free, clear colliding with an error event
                100: i_freeNext = 1'b1;
                105: begin i_clr_err = 1'b1; i_freeNext = 1'b1; end
                108: i_clr_err = 1'b1;
                // reset during WAIT_FREE
                110: begin i_drive = 4'b0100; push_d(112, 2); end
                116: rst = 1'b1;
                118: rst = 1'b0;
                120: i_freeNext = 1'b1;
                // rr pointer restarts at N_PORTS-1 after reset
                124: begin i_drive = 4'b0011; push_d(126, 0); push_d(130, 1); end
                127: begin i_freeNext = 1'b1; push_f(128, 4'b0001); end
                131: begin i_freeNext = 1'b1; push_f(132, 4'b0010); end
                default: ;
            endcase

            #1;
            case (c)
                1: begin
                    chk("rst_busy", 32'(o_busy), 0);
                    chk("rst_drive", 32'(o_driveNext), 0);
                    chk("rst_free", 32'(o_free), 0);
                    chk("rst_owner", 32'(o_owner), 0);
                    chk("rst_errs", 32'({o_err_overrun, o_err_spurious, o_err_timeout}), 0);
                end
                3:   chk("post_rst_busy", 32'(o_busy), 0);
                12:  chk("fair_busy", 32'(o_busy), 1);
                31:  chk("fair_idle", 32'(o_busy), 0);
                42:  chk("single_owner", 32'(o_owner), 2);
                51:  chk("single_busy_rel", 32'(o_busy), 1);
                52: begin
                    chk("single_busy_done", 32'(o_busy), 0);
                    chk("single_no_timeout", 32'(o_err_timeout), 0);
                end
                60:  chk("ovr_before", 32'(o_err_overrun), 0);
                62:  chk("ovr_set", 32'(o_err_overrun), 1);
                65:  chk("ovr_idle", 32'(o_busy), 0);
                70:  chk("ovr_sticky", 32'(o_err_overrun), 1);
                71:  chk("ovr_cleared", 32'(o_err_overrun), 0);
                90: begin
                    chk("to_not_yet", 32'(o_err_timeout), 0);
                    chk("to_busy", 32'(o_busy), 1);
                end
                91:  chk("to_set", 32'(o_err_timeout), 1);
                92:  chk("to_idle", 32'(o_busy), 0);
                100: chk("spur_before", 32'(o_err_spurious), 0);
                101: chk("spur_set", 32'(o_err_spurious), 1);
                106: begin
                    chk("clr_vs_event", 32'(o_err_spurious), 1);
                    chk("clr_timeout", 32'(o_err_timeout), 0);
                end
                109: chk("spur_cleared", 32'(o_err_spurious), 0);
                115: chk("mid_busy", 32'(o_busy), 1);
                116: begin
                    chk("mid_rst_busy", 32'(o_busy), 0);
                    chk("mid_rst_owner", 32'(o_owner), 0);
                    chk("mid_rst_free", 32'(o_free), 0);
                end
                119: chk("mid_rst_spur", 32'(o_err_spurious), 0);
                121: begin
                    chk("late_free_spur", 32'(o_err_spurious), 1);
                    chk("late_free_busy", 32'(o_busy), 0);
                end
                126: chk("ptr_rst_busy", 32'(o_busy), 1);
                133: chk("final_idle", 32'(o_busy), 0);
                default: ;
            endcase
        end

        while (dq.size() != 0) begin
            exp_t e;
            e = dq.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL drive_missing: required owner %0d at cycle %0d, never observed", e.val, e.cyc);
        end
        while (fq.size() != 0) begin
            exp_t e;
            e = fq.pop_front();
            n_cmp++;
            n_fail++;
            $display("FAIL free_missing: required mask %b at cycle %0d, never observed", e.val, e.cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conf_merge_arbiter.md
Name: conf_merge_arbiter

Overview:
- Clocked arbiter that shares one downstream drive/free channel between N_PORTS upstream requesters.
- Synchronous counterpart of the two-input mutex merge, generalised to N ports with fair round-robin selection and single-outstanding-transaction enforcement.
- Sits between FPGA control sources and one shared configuration/compute resource.
- Adds overrun, spurious-free and timeout detection so a stuck resource cannot deadlock the control fabric.

Parameters:
- N_PORTS, 4, number of requesters (2..16).
- IDX_W, $clog2(N_PORTS), width of owner index.
- TIMEOUT, 255, WAIT_FREE cycles before forced release; 0 disables the timeout.
- TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2**TO_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_drive  in  N_PORTS  per-port one-cycle request pulse.
- o_free  out  N_PORTS  per-port one-cycle completion pulse to the served port.
- o_driveNext  out  1  one-cycle drive pulse to the shared resource.
- i_freeNext  in  1  one-cycle completion pulse from the resource.
- o_owner  out  IDX_W  index of the port currently served; valid while o_busy.
- o_busy  out  1  high from grant until release completes.
- i_clr_err  in  1  synchronous clear of sticky error flags.
- o_err_overrun  out  1  sticky: request pulse arrived while the same port was already pending.
- o_err_spurious  out  1  sticky: i_freeNext outside WAIT_FREE.
- o_err_timeout  out  1  sticky: forced release occurred.

Behaviour:
- Reset (async): state=IDLE, pend=0, rr_ptr=N_PORTS-1, counter=0. All outputs 0, including o_owner and all error flags.
- Pending set:
  - i_drive[k] sets pend[k] at the next edge.
  - If pend[k] is already 1, the pulse is dropped and o_err_overrun is set.
  - A port that is currently being served may queue one new request; pend[owner] is independent of the in-flight transaction.
- IDLE:
  - If pend is non-zero, select the first set bit searching upward from rr_ptr+1 with wrap-around.
  - Register owner, clear pend[owner], assert o_busy, go to DRIVE.
  - If a new i_drive and a grant decision fall in the same cycle, the new request is not visible until the following cycle.
- DRIVE: o_driveNext=1 for exactly this one cycle; clear counter; go to WAIT_FREE.
- WAIT_FREE:
  - On i_freeNext=1, go to RELEASE.
  - Otherwise increment counter. If TIMEOUT!=0 and counter==TIMEOUT-1, set o_err_timeout and go to RELEASE (forced release).
- RELEASE:
  - o_free[owner]=1 for exactly one cycle; rr_ptr<=owner; o_busy drops at the exit edge; go to IDLE.
- Spurious free: i_freeNext in IDLE, DRIVE or RELEASE is ignored for state purposes and sets o_err_spurious.
- Latency and throughput:
  - i_drive[k] high in cycle t with the arbiter idle and no other pending ports gives o_driveNext in cycle t+2.
  - i_freeNext in cycle u gives o_free[owner] in cycle u+1.
  - Minimum grant-to-grant spacing is 4 cycles.
- Error clear: i_clr_err clears all sticky flags. An error event in the same cycle takes priority, so the flag stays 1.
- Reset mid-transaction: the transaction is abandoned and no o_free is emitted. A later i_freeNext from the resource is counted as spurious.
- All outputs are registered; o_free and o_driveNext are never asserted in the same cycle.

Decomposition:
- conf_merge_pkg holds:
  - state enum {IDLE, DRIVE, WAIT_FREE, RELEASE} (2 bits);
  - error-bit index constants (ERR_OVERRUN=0, ERR_SPURIOUS=1, ERR_TIMEOUT=2).
- Sub-module rr_pick_n: combinational round-robin picker.
  - Inputs: req[N_PORTS], ptr[IDX_W].
  - Outputs: any, idx.
  - Instantiated once; testable standalone.

Test Plan:
- Single request: pulse i_drive[2] at cycle 10 → o_driveNext at cycle 12, o_owner=2. Then i_freeNext at 20 → o_free=4'b0100 at 21, o_busy=0 from 22.
- Fairness: pend=4'b1111 held continuously, rr_ptr=3 after reset → grant order 0,1,2,3,0. Each o_free goes only to its own port.
- Overrun: two pulses on i_drive[1] with no grant between them → o_err_overrun=1, only one transaction for port 1. Then i_clr_err → flag clears.
- Timeout: TIMEOUT=8, no i_freeNext → o_free[owner] 9 cycles after o_driveNext, o_err_timeout=1, next pending port granted.
- Spurious free and reset mid-flight: i_freeNext in IDLE → o_err_spurious=1. rst asserted in WAIT_FREE → all outputs 0 immediately, no o_free emitted.
